// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^W) multiplier family: FSM encoding,
// default field polynomial and a reference multiply-by-x helper.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         GF_W_DEFAULT    = 4;
    localparam logic [3:0] GF_POLY_DEFAULT = 4'b0011;   // x^4 + x + 1
    localparam int         GF_W_MAX        = 16;

    // Multiply by x in GF(2^w); only the low w bits of a and poly are meaningful.
    function automatic logic [GF_W_MAX-1:0] xtime(
        input logic [GF_W_MAX-1:0] a,
        input int                  w,
        input logic [GF_W_MAX-1:0] poly
    );
        logic [GF_W_MAX:0]   mask_wide;
        logic [GF_W_MAX-1:0] mask;
        mask_wide = (17'd1 << w) - 17'd1;
        mask      = mask_wide[GF_W_MAX-1:0];
        xtime     = ((a << 1) & mask) ^ (a[w-1] ? (poly & mask) : '0);
    endfunction

endpackage

// File: rtl/gf_xtime.sv
// Combinational multiply-by-x in GF(2^W) with the reduction polynomial POLY
// (x^W implicit). Reused by the sequential multiplier and constant multipliers.
module gf_xtime
    import gf_pkg::*;
#(
    parameter int             W    = GF_W_DEFAULT,
    parameter logic [W-1:0]   POLY = W'(GF_POLY_DEFAULT)
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    // Shift left one place and fold the overflowing x^W term back in.
    assign y[0] = a[W-1] & POLY[0];

    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_bit
            assign y[gi] = a[gi-1] ^ (a[W-1] & POLY[gi]);
        end
    endgenerate

endmodule

// File: rtl/gf_mul_seq.sv
// Bit-serial GF(2^W) multiplier with valid/ready handshakes on both sides.
// Optional macro GF_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module gf_mul_seq
    import gf_pkg::*;
#(
    parameter int             W    = GF_W_DEFAULT,
    parameter logic [W-1:0]   POLY = W'(GF_POLY_DEFAULT)
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] A_IN,
    input  logic [W-1:0] B_IN,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] D_OUT
);

    localparam int             CW   = $clog2(W) + 1;
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    state_t         state_reg;
    state_t         state_next;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   acc_reg;
    logic [CW-1:0]  count_reg;
    logic [W-1:0]   a_xtime;
    logic           accept;
    logic           last_step;

    gf_xtime #(
        .W    (W),
        .POLY (POLY)
    ) u_xtime (
        .a (a_reg),
        .y (a_xtime)
    );

`ifdef GF_MUL_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain after this step.
    assign last_step = (count_reg == LAST) || (b_reg[W-1:1] == '0);
`else
    assign last_step = (count_reg == LAST);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        IN_READY   = 1'b0;
        OUT_VALID  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by RST_N so the source sees not-ready during reset.
                IN_READY = RST_N;
                if (IN_VALID && RST_N) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (accept) begin
            a_reg     <= A_IN;
            b_reg     <= B_IN;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (state_reg == BUSY) begin
            if (b_reg[0]) begin
                acc_reg <= acc_reg ^ a_reg;
            end
            a_reg     <= a_xtime;
            b_reg     <= b_reg >> 1;
            count_reg <= count_reg + CW'(1);
        end
    end

    // The accumulator holds its value through DONE, so the product stays stable under backpressure.
    assign D_OUT = acc_reg;

endmodule

// File: tb/tb_gf_mul_seq.sv
// Self-checking bench for gf_mul_seq: GF(16) default field and GF(256) with x^8+x^4+x^3+x+1.
module tb_gf_mul_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv4, ir4, ov4, ordy4;
    logic [3:0] a4, b4, d4;
    logic       iv8, ir8, ov8, ordy8;
    logic [7:0] a8, b8, d8;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [15:0] expq[$];

    always #5 clk = ~clk;

    gf_mul_seq #(.W(4), .POLY(4'b0011)) dut4 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(iv4), .IN_READY(ir4), .A_IN(a4), .B_IN(b4),
        .OUT_VALID(ov4), .OUT_READY(ordy4), .D_OUT(d4)
    );

    gf_mul_seq #(.W(8), .POLY(8'h1B)) dut8 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(iv8), .IN_READY(ir8), .A_IN(a8), .B_IN(b8),
        .OUT_VALID(ov8), .OUT_READY(ordy8), .D_OUT(d8)
    );

    // Reference: full carry-less product, then polynomial long division.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input int w, input logic [15:0] poly);
        logic [31:0] p;
        logic [31:0] full;
        p    = '0;
        full = (32'd1 << w) | {16'd0, poly};
        for (int i = 0; i < w; i++)
            if (b[i]) p = p ^ ({16'd0, a} << i);
        for (int i = 2 * w - 2; i >= w; i--)
            if (p[i]) p = p ^ (full << (i - w));
        return p[15:0];
    endfunction

    function automatic int exp_steps(input logic [15:0] b, input int w);
`ifdef GF_MUL_EARLY_EXIT_EN
        int s = 1;
        for (int i = 0; i < w; i++)
            if (b[i]) s = i + 1;
        return s;
`else
        return (b == 16'hFFFF) ? w : w;
`endif
    endfunction

    function automatic logic in_rdy(input int sel);
        return (sel != 0) ? ir8 : ir4;
    endfunction

    function automatic logic out_vld(input int sel);
        return (sel != 0) ? ov8 : ov4;
    endfunction

    function automatic logic [15:0] dout(input int sel);
        return (sel != 0) ? {8'd0, d8} : {12'd0, d4};
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b);
        if (sel != 0) begin
            iv8 = v; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            iv4 = v; a4 = a[3:0]; b4 = b[3:0];
        end
    endtask

    task automatic set_ordy(input int sel, input logic r);
        if (sel != 0) ordy8 = r;
        else          ordy4 = r;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // One operation with OUT_READY high: checks accept, latency, product and return to IDLE.
    task automatic op(input int sel, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp, input string name);
        int w   = (sel != 0) ? 8 : 4;
        int lat = 0;
        @(negedge clk);
        set_ordy(sel, 1'b1);
        drive_in(sel, 1'b1, a, b);
        chk({name, "_in_ready"}, {15'd0, in_rdy(sel)}, 16'd1);
        @(posedge clk); #1;
        drive_in(sel, 1'b0, 16'd0, 16'd0);
        while (!out_vld(sel) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 16'(lat), 16'(exp_steps(b, w)));
        chk({name, "_product"}, dout(sel), exp);
        @(posedge clk); #1;
        chk({name, "_back_idle"}, {14'd0, in_rdy(sel), out_vld(sel)}, 16'b10);
    endtask

    // Streaming with random input gaps and random OUT_READY; sel 0 is exhaustive.
    task automatic stream(input int sel, input int n);
        int          w    = (sel != 0) ? 8 : 4;
        logic [15:0] poly = (sel != 0) ? 16'h1B : 16'h3;
        int          got  = 0;
        int          cyc  = 0;
        expq.delete();
        fork
            begin : drv
                logic [15:0] a, b;
                int          t;
                bit          stuck = 0;
                for (int i = 0; i < n && !stuck; i++) begin
                    if (sel != 0) begin
                        a = 16'($urandom_range(0, 255));
                        b = 16'($urandom_range(0, 255));
                    end else begin
                        a = 16'(i >> 4);
                        b = 16'(i & 15);
                    end
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    @(negedge clk);
                    drive_in(sel, 1'b1, a, b);
                    t = 0;
                    while (!in_rdy(sel) && t < 100) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 100) begin
                        chk("stream_in_ready_timeout", {15'd0, in_rdy(sel)}, 16'd1);
                        stuck = 1;
                    end else begin
                        expq.push_back(ref_mul(a, b, w, poly));
                        @(posedge clk); #1;
                    end
                    drive_in(sel, 1'b0, 16'd0, 16'd0);
                end
            end
            begin : mon
                logic r;
                while (got < n && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    r = 1'($urandom_range(0, 1));
                    set_ordy(sel, r);
                    if (out_vld(sel) && r) begin
                        if (expq.size() == 0) begin
                            tests_run++;
                            tests_failed++;
                            $display("FAIL stream_spurious: got %h, expected no output", dout(sel));
                        end else begin
                            chk($sformatf("stream%0d_%0d", w, got), dout(sel), expq.pop_front());
                        end
                        got++;
                    end
                end
                chk($sformatf("stream%0d_count", w), 16'(got), 16'(n));
            end
        join
        set_ordy(sel, 1'b1);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] held;
        bit         seen;
        int         lat;

        rst_n = 1'b0;
        iv4 = 0; a4 = 0; b4 = 0; ordy4 = 0;
        iv8 = 0; a8 = 0; b8 = 0; ordy8 = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready4", {15'd0, ir4}, 16'd0);
        chk("reset_in_ready8", {15'd0, ir8}, 16'd0);
        chk("reset_out_valid", {15'd0, ov4}, 16'd0);
        chk("reset_d_out", {12'd0, d4}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_in_ready", {15'd0, ir4}, 16'd1);

        vecs[0] = '{4'h5, 4'h5, 4'h2};
        vecs[1] = '{4'h8, 4'h2, 4'h3};
        vecs[2] = '{4'hF, 4'hF, 4'hA};
        vecs[3] = '{4'h9, 4'h0, 4'h0};
        vecs[4] = '{4'h0, 4'h9, 4'h0};
        vecs[5] = '{4'h7, 4'hB, 4'h4};
        vecs[6] = '{4'h2, 4'h8, 4'h3};
        for (int i = 0; i < 7; i++)
            op(0, {12'd0, vecs[i].a}, {12'd0, vecs[i].b}, {12'd0, vecs[i].d}, $sformatf("vec%0d", i));

        op(1, 16'h57, 16'h83, 16'hC1, "gf256_57x83");

        // Backpressure: hold OUT_READY low for 10 cycles while offering new operands.
        @(negedge clk);
        ordy4 = 1'b0;
        iv4 = 1'b1; a4 = 4'h3; b4 = 4'h6;
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_product", {12'd0, d4}, 16'hA);
        held = d4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
            chk($sformatf("bp_hold_data_%0d", i), {12'd0, d4}, 16'hA);
            chk($sformatf("bp_hold_ctrl_%0d", i), {14'd0, ov4, ir4}, 16'b10);
        end
        @(negedge clk);
        iv4 = 1'b0;
        ordy4 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ctrl", {14'd0, ov4, ir4}, 16'b01);
        seen = 0;
        repeat (7) begin
            @(posedge clk); #1;
            if (ov4) seen = 1;
        end
        chk("bp_no_ghost_result", {15'd0, seen}, 16'd0);
        chk("bp_held_value", {12'd0, held}, 16'hA);

        // Asynchronous reset during the second step of 7*B.
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'h7; b4 = 4'hB;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #3;
        chk("rst_mid_partial_acc", {12'd0, d4}, 16'h7);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {15'd0, ov4}, 16'd0);
        chk("rst_mid_d_out", {12'd0, d4}, 16'd0);
        chk("rst_mid_in_ready", {15'd0, ir4}, 16'd0);
        @(posedge clk); #1;
        chk("rst_hold_in_ready", {15'd0, ir4}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_in_ready", {15'd0, ir4}, 16'd1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov4) seen = 1;
        end
        chk("rst_no_stale_result", {15'd0, seen}, 16'd0);

        stream(0, 256);
        stream(1, 200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
